// File: rtl/stuff_tx_if.sv
// Board-level bus of the bit-stuffing transmitter: push-buttons and switches in,
// green/red LEDs out.
interface stuff_tx_if;
  logic [1:0] KEY;   // [0] clock, [1] start (active low)
  logic [9:0] SW;    // [0] rst_n, [1] stuff_en, [9:2] data word
  logic [2:0] LEDG;  // [0] serial bit, [1] busy, [2] done
  logic [3:0] LEDR;  // stuff bits inserted

  modport master (output KEY, output SW, input LEDG, input LEDR);
  modport slave  (input KEY, input SW, output LEDG, output LEDR);
endinterface

// File: rtl/stuff_tx.sv
// Serial transmitter for an 8-bit word, MSB first, inserting an inverted stuff
// bit after every RUN_LEN identical consecutive bits when stuffing is enabled.
module stuff_tx #(
  parameter int RUN_LEN = 3  // legal range 2..7
) (
  stuff_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] RUN_LIM = 3'(RUN_LEN);

  logic       clk, rst_n, start_n, sw_en;
  logic [7:0] sw_d;

  assign clk     = bus.KEY[0];
  assign start_n = bus.KEY[1];
  assign rst_n   = bus.SW[0];
  assign sw_en   = bus.SW[1];
  assign sw_d    = bus.SW[9:2];

  state_t     state_q;
  logic [7:0] data_q;
  logic [3:0] cnt_q;
  logic [2:0] run_q;
  logic       en_q, w_q, busy_q, done_q;
  logic [3:0] nstuff_q;

  logic       bit_d, stuff_d;
  logic [2:0] run_d;

  // run saturates at 7 so long unstuffed runs cannot wrap back to a small count
  always_comb begin
    bit_d   = data_q[3'(4'd7 - cnt_q)];
    stuff_d = en_q && (run_q == RUN_LIM);
    run_d   = 3'd1;
    if (bit_d == w_q) run_d = (run_q == 3'd7) ? run_q : run_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      run_q    <= '0;
      en_q     <= 1'b0;
      w_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nstuff_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          w_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (!start_n) begin
            data_q   <= sw_d;
            en_q     <= sw_en;
            w_q      <= sw_d[7];
            cnt_q    <= 4'd1;
            run_q    <= 3'd1;
            busy_q   <= 1'b1;
            nstuff_q <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          // stuffing outranks the end-of-frame test so a run closed by bit 8 is still broken
          if (stuff_d) begin
            w_q   <= ~w_q;
            run_q <= 3'd1;
            if (nstuff_q != 4'hF) nstuff_q <= nstuff_q + 4'd1;
          end else if (cnt_q == 4'd8) begin
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            w_q   <= bit_d;
            run_q <= run_d;
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.LEDG = {done_q, busy_q, w_q};
  assign bus.LEDR = nstuff_q;
endmodule

// File: tb/tb_stuff_tx.sv
// Scoreboard bench for stuff_tx: stimulus queues expected frames, a negedge
// monitor collects each frame off LEDG and checks it on the done pulse.
module tb_stuff_tx;
  localparam int RUN_LEN = 3;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          ledr;
    int          gap;   // idle cycles since previous done, -1 = unchecked
    bit          en;
  } exp_t;

  logic       clk = 1'b0, start_n = 1'b1, rst_n = 1'b0, en = 1'b0;
  logic [7:0] d = 8'h00;

  stuff_tx_if bus ();
  assign bus.KEY = {start_n, clk};
  assign bus.SW  = {d, en, rst_n};

  stuff_tx #(.RUN_LEN(RUN_LEN)) dut (.bus(bus));

  always #5 clk = ~clk;

  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp_v);
    end
  endtask

  // monitor
  logic [15:0] m_bits;
  int m_nb = 0, m_run = 0, m_max = 0, m_gap = 0, m_fgap = -1;
  bit m_in = 0, m_after = 0, m_pdone = 0, m_pw = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_in = 0; m_after = 0; m_pdone = 0; m_nb = 0;
    end else begin
      if (bus.LEDG[1]) begin
        if (!m_in) begin
          m_in = 1; m_nb = 0; m_bits = '0; m_run = 0; m_max = 0;
          m_fgap = m_after ? m_gap : -1;
          m_after = 0;
        end
        m_run = (m_nb != 0 && bus.LEDG[0] == m_pw) ? m_run + 1 : 1;
        if (m_run > m_max) m_max = m_run;
        m_pw = bus.LEDG[0];
        m_bits = {m_bits[14:0], bus.LEDG[0]};
        m_nb++;
      end
      if (bus.LEDG[2]) begin
        chk("done_single", int'(m_pdone), 0);
        if (!m_in) chk("done_without_frame", 1, 0);
        else if (q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("frame_bits", int'(m_bits), int'(e.bits));
          chk("frame_len", m_nb, e.len);
          chk("ledr", int'(bus.LEDR), e.ledr);
          if (e.en) chk("run4_detector", int'(m_max > RUN_LEN), 0);
          if (e.gap >= 0) chk("idle_gap", m_fgap, e.gap);
        end
        m_in = 0; m_after = 1; m_gap = 0;
      end else if (!bus.LEDG[1] && m_after) m_gap++;
      m_pdone = bus.LEDG[2];
    end
  end

  task automatic push(input logic [15:0] b, input int len, input int ledr, input int gap, input bit e);
    exp_t x;
    x.bits = b; x.len = len; x.ledr = ledr; x.gap = gap; x.en = e;
    q.push_back(x);
  endtask

  task automatic drain(input string nm);
    int i;
    for (i = 0; i < 60; i++) begin
      if (q.size() == 0 && !bus.LEDG[1]) break;
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL %s_timeout pending=%0d exp=0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic send(input logic [7:0] dv, input bit ev, input logic [15:0] b,
                      input int len, input int ledr, input bit scramble);
    push(b, len, ledr, -1, ev);
    @(posedge clk); #1;
    d = dv; en = ev; start_n = 1'b0;
    @(posedge clk); #1;
    start_n = 1'b1;
    if (scramble) begin d = ~dv; en = ~ev; end
    drain("send");
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ledg", int'(bus.LEDG), 0);
    chk("rst_ledr", int'(bus.LEDR), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ledg", int'(bus.LEDG), 0);

    send(8'hFF, 1'b1, 16'b1110111011, 10, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("ledr_hold", int'(bus.LEDR), 2);
    send(8'hF0, 1'b1, 16'b1110100010, 10, 2, 1'b0);
    send(8'h00, 1'b1, 16'b0001000100, 10, 2, 1'b0);
    send(8'hFF, 1'b0, 16'b11111111,    8, 0, 1'b0);
    send(8'hA5, 1'b1, 16'b10100101,    8, 0, 1'b0);
    send(8'h07, 1'b1, 16'b0001001110, 10, 2, 1'b0);
    send(8'h3C, 1'b1, 16'b001110100,   9, 1, 1'b0);
    send(8'h80, 1'b1, 16'b1000100010, 10, 2, 1'b0);
    send(8'hFF, 1'b1, 16'b1110111011, 10, 2, 1'b1);
    send(8'h0F, 1'b0, 16'b00001111,    8, 0, 1'b1);

    // back-to-back frames with start held low
    push(16'b0001011101, 10, 2, -1, 1'b1);
    push(16'b0001011101, 10, 2,  1, 1'b1);
    push(16'b0001011101, 10, 2,  1, 1'b1);
    @(posedge clk); #1;
    d = 8'h0F; en = 1'b1; start_n = 1'b0;
    for (int i = 0; i < 60 && q.size() > 1; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 10 && !bus.LEDG[1]; i++) begin @(posedge clk); #1; end
    start_n = 1'b1;
    drain("b2b");

    // reset on the fifth bit of a stuffed 0xFF frame
    @(posedge clk); #1;
    d = 8'hFF; en = 1'b1; start_n = 1'b0;
    @(posedge clk); #1;
    start_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(bus.LEDG[1]), 1);
    chk("pre_rst_ledr", int'(bus.LEDR), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ledg", int'(bus.LEDG), 0);
    chk("abort_ledr", int'(bus.LEDR), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.LEDG != 3'b000) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    send(8'hFF, 1'b1, 16'b1110111011, 10, 2, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stuff_tx.md
STUFF_TX -- requirements
Module: stuff_tx

Interface
REQ-001 Parameter RUN_LEN, default 3, is the number of identical consecutive bits after which a stuff bit is inserted; legal range 2..7.
REQ-002 KEY[0]  input  1  clock; all state changes occur on its rising edge.
REQ-003 SW[0]  input  1  reset; asynchronous, active-low.
REQ-004 SW[1]  input  1  stuff_en; 1 = insert stuff bits, 0 = send raw data.
REQ-005 SW[9:2]  input  8  data word D, sent MSB (SW[9]) first.
REQ-006 KEY[1]  input  1  start, active-low level, sampled on the clock edge.
REQ-007 LEDG[0]  output  1  serial bit w, registered.
REQ-008 LEDG[1]  output  1  busy; high while a frame is on LEDG[0].
REQ-009 LEDG[2]  output  1  done; one-cycle pulse after the last bit of a frame.
REQ-010 LEDR[3:0]  output  4  stuff bits inserted in the current or last frame.

Function
REQ-011 The block SHALL implement states IDLE, SEND and DONE, plus internal regs: 8-bit shift/data reg, 4-bit bit_cnt (0..8), 3-bit run counter and 1-bit stuff_en latch.
REQ-012 IDLE behaviour on each edge:
- outputs: LEDG[0]=0, busy=0, done=0.
- if KEY[1]==0: latch D and SW[1]; set LEDG[0]<=D[7], bit_cnt<=1, run<=1, busy<=1, LEDR<=0; go to SEND.
REQ-013 SEND behaviour on each edge, evaluated in priority order:
- (a) stuff_en latched, and run==RUN_LEN: LEDG[0]<=~LEDG[0], run<=1, LEDR<=LEDR+1 (saturating at 15); bit_cnt is unchanged.
- (b) otherwise, if bit_cnt==8: LEDG[0]<=0, busy<=0, done<=1; go to DONE.
- (c) otherwise: LEDG[0]<=D[7-bit_cnt]; run<=(new bit==LEDG[0]) ? run+1 : 1; bit_cnt<=bit_cnt+1.
REQ-014 Run counting SHALL be applied uniformly to data and stuff bits, so a stuff bit starts a new run of length 1.
REQ-015 A stuff bit SHALL still be appended when the run limit is reached on the eighth data bit, before the frame ends.
REQ-016 Every frame SHALL start with run=1, regardless of the previous frame or the idle level.
REQ-017 Frame length:
- busy is high for exactly 8 + LEDR cycles.
- with stuff_en=0 the frame SHALL be exactly 8 cycles and LEDR SHALL stay 0.
REQ-018 With stuff_en=1 and RUN_LEN<=3, LEDG[0] SHALL never carry more than RUN_LEN identical consecutive bits within a frame. This is the guarantee that the run-of-four detector never fires on valid traffic.
REQ-019 DONE SHALL last one cycle with done=1, then go to IDLE; start is ignored in DONE and SEND.
REQ-020 With KEY[1] held low, frames SHALL repeat: SEND, DONE, then one IDLE cycle that samples start.
REQ-021 SW[9:1] changes while busy SHALL have no effect on the frame in flight.
REQ-022 LEDR SHALL hold its value after DONE until the next frame start clears it.

Reset
REQ-023 When SW[0]=0, the block SHALL immediately clear all of the following: state to IDLE, LEDG[2:0] to 0, LEDR[3:0] to 0, bit_cnt to 0, run to 0, and the data and stuff_en latches to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame: no done pulse and no partial completion after release.
REQ-025 After reset releases, the first frame SHALL start only on a clock edge that samples KEY[1]==0 in IDLE.

Verification
REQ-026 D=0xFF, SW[1]=1, RUN_LEN=3 -> LEDG[0] = 1110111011, busy 10 cycles, LEDR=2, single done pulse.
REQ-027 D=0xF0, SW[1]=1 -> LEDG[0] = 1110100010, LEDR=2; D=0x00 -> 0001000100, LEDR=2.
REQ-028 D=0xFF, SW[1]=0 -> LEDG[0] = 11111111, busy 8 cycles, LEDR=0; D=0xA5, SW[1]=1 -> 10100101, LEDR=0.
REQ-029 SW[0] pulled low on the 5th bit of a D=0xFF frame -> all LEDG/LEDR bits 0 at once, no done pulse; the next frame after release is correct.
REQ-030 KEY[1] held low with random D -> back-to-back frames, each with one DONE and one IDLE cycle between.
REQ-031 Random D with SW[1]=1 -> check no run of RUN_LEN+1 on LEDG[0]; feed LEDG[0] into the run-of-four detector, whose output SHALL stay 0.
